// File: rtl/cpu_clk_pkg.sv
// Shared types for the CPU clock controller: controller states, the cycle
// counter width and the state-transition rule.
package cpu_clk_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STEP   = 2'd1,
        HALTED = 2'd2
    } clk_state_e;

    localparam int CYCLE_COUNT_W = 16;

    // HALTED is sticky; only reset leaves it, and halt beats any mode change.
    function automatic clk_state_e next_state(input clk_state_e cur,
                                              input logic       mode_sel,
                                              input logic       halt);
        clk_state_e nxt;
        nxt = cur;
        if (cur != HALTED) begin
            if (halt) begin
                nxt = HALTED;
            end else if (mode_sel) begin
                nxt = STEP;
            end else begin
                nxt = RUN;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton front end: 2-flop synchronizer, level debouncer and a one-cycle
// press pulse on each accepted 0->1 transition.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 120000
) (
    input  logic fastClk,
    input  logic rst_n,
    input  logic btnRaw,
    output logic btnStable,
    output logic btnPress
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic             stable_prev_q, stable_prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d       = btnRaw;
        sync2_d       = sync1_q;
        stable_prev_d = stable_q;
        stable_d      = stable_q;
        cnt_d         = '0;
        // A single cycle of agreement restarts the qualification window.
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge fastClk) begin
        if (!rst_n) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            stable_q      <= stable_d;
            stable_prev_q <= stable_prev_d;
            cnt_q         <= cnt_d;
        end
    end

    assign btnStable = stable_q;
    assign btnPress  = stable_q & ~stable_prev_q;

endmodule

// File: rtl/clock_control.sv
// CPU clock controller: auto/manual clock-enable generation with sticky halt.
// Define CLKCTRL_CYCLE_COUNT_EN to build the issued-pulse counter on cycleCount.
module clock_control
    import cpu_clk_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 120000
) (
    input  logic                     fastClk,
    input  logic                     rst_n,
    input  logic                     tickIn,
    input  logic                     modeSel,
    input  logic                     stepBtn,
    input  logic                     halt,
    output logic                     clkEn,
    output logic                     cpuClk,
    output logic                     halted,
    output logic [CYCLE_COUNT_W-1:0] cycleCount
);

    logic       btn_stable;
    logic       btn_press;
    logic       tick_rise;
    clk_state_e state_q, state_d;
    logic       tick_prev_q, tick_prev_d;
    logic       clk_en_q, clk_en_d;
    logic       cpu_clk_q, cpu_clk_d;
    logic       halted_q, halted_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .fastClk  (fastClk),
        .rst_n    (rst_n),
        .btnRaw   (stepBtn),
        .btnStable(btn_stable),
        .btnPress (btn_press)
    );

    assign tick_rise = tickIn & ~tick_prev_q;

    always_comb begin
        tick_prev_d = tickIn;
        state_d     = next_state(state_q, modeSel, halt);
        // Events are qualified by the state held this cycle, so a pulse that
        // coincides with a mode change follows the old mode.
        clk_en_d = 1'b0;
        if (!halt) begin
            case (state_q)
                RUN:     clk_en_d = tick_rise;
                STEP:    clk_en_d = btn_press;
                default: clk_en_d = 1'b0;
            endcase
        end
        // The LED follows the state being entered so it drops with the halt.
        case (state_d)
            RUN:     cpu_clk_d = tickIn;
            STEP:    cpu_clk_d = btn_stable;
            default: cpu_clk_d = 1'b0;
        endcase
        halted_d = (state_d == HALTED);
    end

    always_ff @(posedge fastClk) begin
        if (!rst_n) begin
            state_q     <= RUN;
            tick_prev_q <= 1'b0;
            clk_en_q    <= 1'b0;
            cpu_clk_q   <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_prev_q <= tick_prev_d;
            clk_en_q    <= clk_en_d;
            cpu_clk_q   <= cpu_clk_d;
            halted_q    <= halted_d;
        end
    end

    assign clkEn  = clk_en_q;
    assign cpuClk = cpu_clk_q;
    assign halted = halted_q;

`ifdef CLKCTRL_CYCLE_COUNT_EN
    logic [CYCLE_COUNT_W-1:0] count_q, count_d;

    // Counts in step with clkEn so the value already includes the pulse shown.
    always_comb begin
        count_d = count_q;
        if (clk_en_d) begin
            count_d = count_q + CYCLE_COUNT_W'(1);
        end
    end

    always_ff @(posedge fastClk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign cycleCount = count_q;
`else
    assign cycleCount = '0;
`endif

endmodule

// File: tb/tb_clock_control.sv
// Directed bench for clock_control with a per-cycle reference model compare.
module tb_clock_control;

    localparam int DB = 4;

    logic        fastClk;
    logic        rst_n;
    logic        tickIn;
    logic        modeSel;
    logic        stepBtn;
    logic        halt;
    logic        clkEn;
    logic        cpuClk;
    logic        halted;
    logic [15:0] cycleCount;

    int n_checks = 0;
    int n_pass   = 0;
    int pulses   = 0;

    clock_control #(
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .fastClk   (fastClk),
        .rst_n     (rst_n),
        .tickIn    (tickIn),
        .modeSel   (modeSel),
        .stepBtn   (stepBtn),
        .halt      (halt),
        .clkEn     (clkEn),
        .cpuClk    (cpuClk),
        .halted    (halted),
        .cycleCount(cycleCount)
    );

    initial begin
        fastClk = 1'b0;
        forever #5 fastClk = ~fastClk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_cnt(input int n);
`ifdef CLKCTRL_CYCLE_COUNT_EN
        return 16'(n);
`else
        return 16'(0 * n);
`endif
    endfunction

    // Advance n edges; inputs may be changed right after return, outputs then
    // reflect the edge just passed.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge fastClk);
            #2;
            if (clkEn === 1'b1) pulses++;
        end
    endtask

    // ---------------- reference model + per-cycle compare ----------------
    // mode: 0 run, 1 step, 2 halted
    int          m_mode;
    bit          m_valid = 0;
    bit          m_tick_prev, m_stable, m_press_evt, m_cpu, m_clk_en, m_halted;
    bit          m_seen, m_rise, m_stable_pre, m_fire;
    logic [15:0] m_count;
    bit          raw_pipe[$];
    bit          streak[$];

    initial begin
        forever begin
            @(posedge fastClk);
            if (!rst_n) begin
                m_mode      = 0;
                m_tick_prev = 0;
                m_stable    = 0;
                m_press_evt = 0;
                m_cpu       = 0;
                m_clk_en    = 0;
                m_halted    = 0;
                m_count     = '0;
                raw_pipe    = '{1'b0, 1'b0};
                streak.delete();
                m_valid     = 1;
            end else if (m_valid) begin
                // Button level reaching the debouncer lags the pin by two edges.
                m_seen = raw_pipe.pop_front();
                raw_pipe.push_back(stepBtn);
                m_rise       = tickIn && !m_tick_prev;
                m_stable_pre = m_stable;
                m_fire = !halt && ((m_mode == 0 && m_rise) || (m_mode == 1 && m_press_evt));
                m_press_evt = 0;
                if (m_seen == m_stable) begin
                    streak.delete();
                end else begin
                    streak.push_back(m_seen);
                    if (streak.size() == DB) begin
                        m_stable    = m_seen;
                        m_press_evt = m_seen;
                        streak.delete();
                    end
                end
                if (m_mode != 2) m_mode = halt ? 2 : (modeSel ? 1 : 0);
                m_cpu    = (m_mode == 2) ? 1'b0 : ((m_mode == 0) ? tickIn : m_stable_pre);
                m_clk_en = m_fire;
                if (m_fire) m_count = m_count + 16'd1;
                m_halted    = (m_mode == 2);
                m_tick_prev = tickIn;
            end
            @(negedge fastClk);
            if (m_valid) begin
                chk("model clkEn", 32'(clkEn), 32'(m_clk_en));
                chk("model cpuClk", 32'(cpuClk), 32'(m_cpu));
                chk("model halted", 32'(halted), 32'(m_halted));
                chk("model cycleCount", 32'(cycleCount), 32'(exp_cnt(int'(m_count))));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        rst_n = 1'b0; tickIn = 1'b0; modeSel = 1'b0; stepBtn = 1'b0; halt = 1'b0;
        step(2);
        chk("reset clkEn", 32'(clkEn), 32'd0);
        chk("reset cpuClk", 32'(cpuClk), 32'd0);
        chk("reset halted", 32'(halted), 32'd0);
        chk("reset cycleCount", 32'(cycleCount), 32'd0);
        rst_n = 1'b1;
        step(2);

        // Auto mode: three tick edges, one pulse each, one cycle late.
        for (int i = 0; i < 3; i++) begin
            tickIn = 1'b1;
            chk("auto pre-edge clkEn", 32'(clkEn), 32'd0);
            step(1);
            chk("auto pulse clkEn", 32'(clkEn), 32'd1);
            step(1);
            chk("auto pulse width", 32'(clkEn), 32'd0);
            step(6);
            tickIn = 1'b0;
            step(8);
        end
        chk("auto cycleCount", 32'(cycleCount), 32'(exp_cnt(3)));
        $display("auto ticks: cycleCount=%0d", cycleCount);

        // Manual mode: bouncing button yields exactly one step.
        modeSel = 1'b1;
        step(2);
        pulses = 0;
        stepBtn = 1'b1; step(2);
        stepBtn = 1'b0; step(2);
        stepBtn = 1'b1; step(10);
        stepBtn = 1'b0; step(8);
        chk("bounce pulses", 32'(pulses), 32'd1);
        chk("bounce cycleCount", 32'(cycleCount), 32'(exp_cnt(4)));
        $display("manual bounce: pulses=%0d cycleCount=%0d", pulses, cycleCount);

        // Halt coinciding with a tick edge wins; halted state ignores events.
        modeSel = 1'b0;
        step(2);
        tickIn = 1'b1; halt = 1'b1;
        step(1);
        chk("halt clkEn", 32'(clkEn), 32'd0);
        chk("halt halted", 32'(halted), 32'd1);
        chk("halt cpuClk", 32'(cpuClk), 32'd0);
        halt = 1'b0;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            tickIn = 1'b0; step(4);
            tickIn = 1'b1; step(4);
        end
        modeSel = 1'b1;
        stepBtn = 1'b1; step(10);
        stepBtn = 1'b0; step(8);
        chk("halted pulses", 32'(pulses), 32'd0);
        chk("halted sticky", 32'(halted), 32'd1);
        chk("halted cycleCount", 32'(cycleCount), 32'(exp_cnt(4)));
        $display("halt: halted=%0d pulses=%0d", halted, pulses);

        // Reset leaves HALTED; next tick edge steps the CPU again.
        rst_n = 1'b0; tickIn = 1'b0; modeSel = 1'b0;
        step(1);
        chk("rst clkEn", 32'(clkEn), 32'd0);
        chk("rst cpuClk", 32'(cpuClk), 32'd0);
        chk("rst halted", 32'(halted), 32'd0);
        chk("rst cycleCount", 32'(cycleCount), 32'd0);
        rst_n = 1'b1;
        step(1);
        tickIn = 1'b1;
        step(1);
        chk("post-rst clkEn", 32'(clkEn), 32'd1);
        chk("post-rst cycleCount", 32'(cycleCount), 32'(exp_cnt(1)));
        $display("reset recovery: clkEn=%0d cycleCount=%0d", clkEn, cycleCount);

        // Button held through reset needs a full post-reset debounce window.
        tickIn = 1'b0; modeSel = 1'b1; stepBtn = 1'b1;
        step(2);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        pulses = 0;
        step(4);
        chk("held-btn early pulses", 32'(pulses), 32'd0);
        step(8);
        chk("held-btn pulses", 32'(pulses), 32'd1);
        stepBtn = 1'b0;
        step(8);
        $display("held through reset: pulses=%0d", pulses);

        modeSel = 1'b0; rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(1);
`ifdef CLKCTRL_CYCLE_COUNT_EN
        for (int i = 0; i < 65535; i++) begin
            tickIn = 1'b1; step(1);
            tickIn = 1'b0; step(1);
        end
        chk("wrap at ffff", 32'(cycleCount), 32'h0000_ffff);
        tickIn = 1'b1; step(1);
        chk("wrap to 0", 32'(cycleCount), 32'd0);
        tickIn = 1'b0; step(1);
        tickIn = 1'b1; step(1);
        chk("wrap to 1", 32'(cycleCount), 32'd1);
        tickIn = 1'b0; step(2);
        $display("wrap: cycleCount=%0d", cycleCount);
`else
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tickIn = 1'b1; step(1);
            tickIn = 1'b0; step(1);
        end
        step(1);
        chk("no-counter pulses", 32'(pulses), 32'd20);
        chk("no-counter cycleCount", 32'(cycleCount), 32'd0);
        $display("counter disabled: pulses=%0d cycleCount=%0d", pulses, cycleCount);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
